// File: rtl/blake2_sched_pkg.sv
// Shared constants for the BLAKE2 F-function round/step sequencer:
// message permutation table, G-position tables, FSM encoding and
// the steps-per-round helper.
package blake2_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // State-word positions for the eight G calls of a round:
    // entries 0..3 are the columns, 4..7 the diagonals.
    localparam logic [3:0] G_A [0:7] = '{4'd0, 4'd1, 4'd2,  4'd3,  4'd0,  4'd1,  4'd2,  4'd3};
    localparam logic [3:0] G_B [0:7] = '{4'd4, 4'd5, 4'd6,  4'd7,  4'd5,  4'd6,  4'd7,  4'd4};
    localparam logic [3:0] G_C [0:7] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd10, 4'd11, 4'd8,  4'd9};
    localparam logic [3:0] G_D [0:7] = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd12, 4'd13, 4'd14};

    // Message-word permutation, one row per round (rounds 10/11 reuse rows 0/1).
    localparam logic [3:0] SIGMA [0:9][0:15] = '{
        '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hb, 4'hc, 4'hd, 4'he, 4'hf},
        '{4'he, 4'ha, 4'h4, 4'h8, 4'h9, 4'hf, 4'hd, 4'h6, 4'h1, 4'hc, 4'h0, 4'h2, 4'hb, 4'h7, 4'h5, 4'h3},
        '{4'hb, 4'h8, 4'hc, 4'h0, 4'h5, 4'h2, 4'hf, 4'hd, 4'ha, 4'he, 4'h3, 4'h6, 4'h7, 4'h1, 4'h9, 4'h4},
        '{4'h7, 4'h9, 4'h3, 4'h1, 4'hd, 4'hc, 4'hb, 4'he, 4'h2, 4'h6, 4'h5, 4'ha, 4'h4, 4'h0, 4'hf, 4'h8},
        '{4'h9, 4'h0, 4'h5, 4'h7, 4'h2, 4'h4, 4'ha, 4'hf, 4'he, 4'h1, 4'hb, 4'hc, 4'h6, 4'h8, 4'h3, 4'hd},
        '{4'h2, 4'hc, 4'h6, 4'ha, 4'h0, 4'hb, 4'h8, 4'h3, 4'h4, 4'hd, 4'h7, 4'h5, 4'hf, 4'he, 4'h1, 4'h9},
        '{4'hc, 4'h5, 4'h1, 4'hf, 4'he, 4'hd, 4'h4, 4'ha, 4'h0, 4'h7, 4'h6, 4'h3, 4'h9, 4'h2, 4'h8, 4'hb},
        '{4'hd, 4'hb, 4'h7, 4'he, 4'hc, 4'h1, 4'h3, 4'h9, 4'h5, 4'h0, 4'hf, 4'h4, 4'h8, 4'h6, 4'h2, 4'ha},
        '{4'h6, 4'hf, 4'he, 4'h9, 4'hb, 4'h3, 4'h0, 4'h8, 4'hc, 4'h2, 4'hd, 4'h7, 4'h1, 4'h4, 4'ha, 4'h5},
        '{4'ha, 4'h2, 4'h8, 4'h4, 4'h7, 4'h6, 4'h1, 4'h5, 4'hf, 4'hb, 4'h9, 4'he, 4'h3, 4'hc, 4'hd, 4'h0}
    };

    // Steps needed to issue all eight G calls of a round with the given lane count.
    function automatic int steps_per_round(input int lanes);
        if (lanes > 32'sd0) begin
            return 32'sd8 / lanes;
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage

// File: rtl/g_lane_sel.sv
// Combinational selector lookup for one G lane: global G index plus
// permutation row give the four state-word and two message-word indices.
module g_lane_sel
    import blake2_sched_pkg::*;
(
    input  logic [2:0] i_g,
    input  logic [3:0] i_row,
    output logic [3:0] o_a,
    output logic [3:0] o_b,
    output logic [3:0] o_c,
    output logic [3:0] o_d,
    output logic [3:0] o_m0,
    output logic [3:0] o_m1
);

    // Table lookup; rows beyond the permutation table read as zero.
    always_comb begin
        o_a = G_A[i_g];
        o_b = G_B[i_g];
        o_c = G_C[i_g];
        o_d = G_D[i_g];
        if (i_row < 4'd10) begin
            o_m0 = SIGMA[i_row][{i_g, 1'b0}];
            o_m1 = SIGMA[i_row][{i_g, 1'b1}];
        end else begin
            o_m0 = 4'd0;
            o_m1 = 4'd0;
        end
    end

endmodule

// File: rtl/f_seq.sv
// BLAKE2 F round/step sequencer. Walks every round of one compression and
// presents LANES G-operand selector sets per step over valid/ready.
// The bundle for the next (rnd, step) is looked up combinationally and
// captured into the output registers whenever the position advances.
module f_seq
    import blake2_sched_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int ROUNDS = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               sel_valid,
    input  logic               sel_ready,
    output logic [3:0]         rnd,
    output logic [2:0]         step,
    output logic               last,
    output logic [4*LANES-1:0] a_sel,
    output logic [4*LANES-1:0] b_sel,
    output logic [4*LANES-1:0] c_sel,
    output logic [4*LANES-1:0] d_sel,
    output logic [4*LANES-1:0] m0_sel,
    output logic [4*LANES-1:0] m1_sel
);

    localparam int         W        = 4 * LANES;
    localparam int         S        = steps_per_round(LANES);
    localparam logic [2:0] STEP_MAX = 3'(S - 1);
    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    generate
        if (!((LANES == 32'sd1) || (LANES == 32'sd2) || (LANES == 32'sd4)) ||
            (ROUNDS < 32'sd1) || (ROUNDS > 32'sd16)) begin : g_bad_cfg
            $fatal(1, "f_seq: LANES must be 1, 2 or 4 and ROUNDS 1..16");
        end
    endgenerate

    logic [1:0]   r_state;
    logic [3:0]   r_rnd;
    logic [2:0]   r_step;
    logic         r_busy, r_done, r_valid, r_last;
    logic [W-1:0] r_a, r_b, r_c, r_d, r_m0, r_m1;

    logic [1:0]   w_nxt_state;
    logic [3:0]   w_nxt_rnd;
    logic [2:0]   w_nxt_step;
    logic         w_nxt_busy, w_nxt_done, w_nxt_valid, w_nxt_last;
    logic         w_load, w_clear;
    logic [3:0]   w_row;
    logic [W-1:0] w_a, w_b, w_c, w_d, w_m0, w_m1;

    // Permutation row for the position being loaded (rounds 10+ wrap).
    assign w_row = (w_nxt_rnd >= 4'd10) ? (w_nxt_rnd - 4'd10) : w_nxt_rnd;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [2:0] w_g;
        assign w_g = 3'(int'(w_nxt_step) * LANES + k);
        g_lane_sel u_sel (
            .i_g   (w_g),
            .i_row (w_row),
            .o_a   (w_a[4*k+3:4*k]),
            .o_b   (w_b[4*k+3:4*k]),
            .o_c   (w_c[4*k+3:4*k]),
            .o_d   (w_d[4*k+3:4*k]),
            .o_m0  (w_m0[4*k+3:4*k]),
            .o_m1  (w_m1[4*k+3:4*k])
        );
    end

    // Next-state decode: abort wins, then handshake/advance, then start.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_rnd   = r_rnd;
        w_nxt_step  = r_step;
        w_nxt_busy  = r_busy;
        w_nxt_valid = r_valid;
        w_nxt_done  = 1'b0;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        if (abort) begin
            w_nxt_state = S_IDLE;
            w_nxt_rnd   = 4'd0;
            w_nxt_step  = 3'd0;
            w_nxt_busy  = 1'b0;
            w_nxt_valid = 1'b0;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (sel_ready) begin
                        if (r_last) begin
                            w_nxt_state = S_DONE;
                            w_nxt_rnd   = 4'd0;
                            w_nxt_step  = 3'd0;
                            w_nxt_busy  = 1'b0;
                            w_nxt_valid = 1'b0;
                            w_nxt_done  = 1'b1;
                            w_clear     = 1'b1;
                        end else if (r_step == STEP_MAX) begin
                            w_nxt_step = 3'd0;
                            w_nxt_rnd  = r_rnd + 4'd1;
                            w_load     = 1'b1;
                        end else begin
                            w_nxt_step = r_step + 3'd1;
                            w_load     = 1'b1;
                        end
                    end else begin
                        w_load = 1'b0;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_nxt_state = S_RUN;
                        w_nxt_rnd   = 4'd0;
                        w_nxt_step  = 3'd0;
                        w_nxt_busy  = 1'b1;
                        w_nxt_valid = 1'b1;
                        w_load      = 1'b1;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_rnd   = 4'd0;
                        w_nxt_step  = 3'd0;
                        w_nxt_busy  = 1'b0;
                        w_nxt_valid = 1'b0;
                        w_clear     = 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_rnd   = 4'd0;
                    w_nxt_step  = 3'd0;
                    w_nxt_busy  = 1'b0;
                    w_nxt_valid = 1'b0;
                    w_clear     = 1'b1;
                end
            endcase
        end
        if (w_load) begin
            w_nxt_last = (w_nxt_rnd == LAST_RND) && (w_nxt_step == STEP_MAX);
        end else if (w_clear) begin
            w_nxt_last = 1'b0;
        end else begin
            w_nxt_last = r_last;
        end
    end

    // Control and position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rnd   <= 4'd0;
            r_step  <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_rnd   <= w_nxt_rnd;
            r_step  <= w_nxt_step;
            r_busy  <= w_nxt_busy;
            r_done  <= w_nxt_done;
            r_valid <= w_nxt_valid;
            r_last  <= w_nxt_last;
        end
    end

    // Selector bundle registers: load on advance, clear on leaving RUN, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= {W{1'b0}};
            r_b  <= {W{1'b0}};
            r_c  <= {W{1'b0}};
            r_d  <= {W{1'b0}};
            r_m0 <= {W{1'b0}};
            r_m1 <= {W{1'b0}};
        end else if (w_load) begin
            r_a  <= w_a;
            r_b  <= w_b;
            r_c  <= w_c;
            r_d  <= w_d;
            r_m0 <= w_m0;
            r_m1 <= w_m1;
        end else if (w_clear) begin
            r_a  <= {W{1'b0}};
            r_b  <= {W{1'b0}};
            r_c  <= {W{1'b0}};
            r_d  <= {W{1'b0}};
            r_m0 <= {W{1'b0}};
            r_m1 <= {W{1'b0}};
        end else begin
            r_a  <= r_a;
            r_b  <= r_b;
            r_c  <= r_c;
            r_d  <= r_d;
            r_m0 <= r_m0;
            r_m1 <= r_m1;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign sel_valid = r_valid;
    assign rnd       = r_rnd;
    assign step      = r_step;
    assign last      = r_last;
    assign a_sel     = r_a;
    assign b_sel     = r_b;
    assign c_sel     = r_c;
    assign d_sel     = r_d;
    assign m0_sel    = r_m0;
    assign m1_sel    = r_m1;

endmodule

// File: tb/tb_f_seq.sv
// Bench for f_seq: one LANES=1/ROUNDS=12 instance and one LANES=4/ROUNDS=10
// instance, each compared every cycle against a transfer-index model.
module tb_f_seq;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic t_start [2];
    logic t_abort [2];
    logic t_ready [2];

    logic        o1_busy, o1_done, o1_valid, o1_last;
    logic [3:0]  o1_rnd;
    logic [2:0]  o1_step;
    logic [3:0]  o1_a, o1_b, o1_c, o1_d, o1_m0, o1_m1;
    logic        o4_busy, o4_done, o4_valid, o4_last;
    logic [3:0]  o4_rnd;
    logic [2:0]  o4_step;
    logic [15:0] o4_a, o4_b, o4_c, o4_d, o4_m0, o4_m1;

    logic [127:0] obs [2];

    int errors = 0;
    int checks = 0;
    int m_st  [2];
    int m_idx [2];
    int xfers [2];
    int dones [2];

    logic [3:0] sig [10][16] = '{
        '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hb, 4'hc, 4'hd, 4'he, 4'hf},
        '{4'he, 4'ha, 4'h4, 4'h8, 4'h9, 4'hf, 4'hd, 4'h6, 4'h1, 4'hc, 4'h0, 4'h2, 4'hb, 4'h7, 4'h5, 4'h3},
        '{4'hb, 4'h8, 4'hc, 4'h0, 4'h5, 4'h2, 4'hf, 4'hd, 4'ha, 4'he, 4'h3, 4'h6, 4'h7, 4'h1, 4'h9, 4'h4},
        '{4'h7, 4'h9, 4'h3, 4'h1, 4'hd, 4'hc, 4'hb, 4'he, 4'h2, 4'h6, 4'h5, 4'ha, 4'h4, 4'h0, 4'hf, 4'h8},
        '{4'h9, 4'h0, 4'h5, 4'h7, 4'h2, 4'h4, 4'ha, 4'hf, 4'he, 4'h1, 4'hb, 4'hc, 4'h6, 4'h8, 4'h3, 4'hd},
        '{4'h2, 4'hc, 4'h6, 4'ha, 4'h0, 4'hb, 4'h8, 4'h3, 4'h4, 4'hd, 4'h7, 4'h5, 4'hf, 4'he, 4'h1, 4'h9},
        '{4'hc, 4'h5, 4'h1, 4'hf, 4'he, 4'hd, 4'h4, 4'ha, 4'h0, 4'h7, 4'h6, 4'h3, 4'h9, 4'h2, 4'h8, 4'hb},
        '{4'hd, 4'hb, 4'h7, 4'he, 4'hc, 4'h1, 4'h3, 4'h9, 4'h5, 4'h0, 4'hf, 4'h4, 4'h8, 4'h6, 4'h2, 4'ha},
        '{4'h6, 4'hf, 4'he, 4'h9, 4'hb, 4'h3, 4'h0, 4'h8, 4'hc, 4'h2, 4'hd, 4'h7, 4'h1, 4'h4, 4'ha, 4'h5},
        '{4'ha, 4'h2, 4'h8, 4'h4, 4'h7, 4'h6, 4'h1, 4'h5, 4'hf, 4'hb, 4'h9, 4'he, 4'h3, 4'hc, 4'hd, 4'h0}
    };

    f_seq #(.LANES(1), .ROUNDS(12)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(t_start[0]), .abort(t_abort[0]),
        .busy(o1_busy), .done(o1_done), .sel_valid(o1_valid), .sel_ready(t_ready[0]),
        .rnd(o1_rnd), .step(o1_step), .last(o1_last),
        .a_sel(o1_a), .b_sel(o1_b), .c_sel(o1_c), .d_sel(o1_d), .m0_sel(o1_m0), .m1_sel(o1_m1)
    );

    f_seq #(.LANES(4), .ROUNDS(10)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(t_start[1]), .abort(t_abort[1]),
        .busy(o4_busy), .done(o4_done), .sel_valid(o4_valid), .sel_ready(t_ready[1]),
        .rnd(o4_rnd), .step(o4_step), .last(o4_last),
        .a_sel(o4_a), .b_sel(o4_b), .c_sel(o4_c), .d_sel(o4_d), .m0_sel(o4_m0), .m1_sel(o4_m1)
    );

    always #5 clk = ~clk;

    assign obs[0] = {21'd0, o1_valid, o1_busy, o1_done, o1_last, o1_rnd, o1_step,
                     12'd0, o1_a, 12'd0, o1_b, 12'd0, o1_c, 12'd0, o1_d, 12'd0, o1_m0, 12'd0, o1_m1};
    assign obs[1] = {21'd0, o4_valid, o4_busy, o4_done, o4_last, o4_rnd, o4_step,
                     o4_a, o4_b, o4_c, o4_d, o4_m0, o4_m1};

    function automatic int total(input int d);
        return (d == 0) ? 12 * 8 : 10 * 2;
    endfunction

    // Expected outputs from the model's state and transfer index.
    function automatic logic [127:0] exp_vec(input int d);
        int lanes, sp, r, s, g, i, row;
        logic [15:0] ea, eb, ec, ed, em0, em1;
        logic v, b, dn, l;
        logic [3:0] er;
        logic [2:0] es;
        lanes = (d == 0) ? 1 : 4;
        sp = 8 / lanes;
        ea = 16'd0; eb = 16'd0; ec = 16'd0; ed = 16'd0; em0 = 16'd0; em1 = 16'd0;
        v = 1'b0; b = 1'b0; dn = 1'b0; l = 1'b0; er = 4'd0; es = 3'd0;
        if (m_st[d] == M_RUN) begin
            v = 1'b1;
            b = 1'b1;
            r = m_idx[d] / sp;
            s = m_idx[d] % sp;
            er = 4'(r);
            es = 3'(s);
            l = (m_idx[d] == total(d) - 1);
            row = r % 10;
            for (int k = 0; k < lanes; k++) begin
                g = s * lanes + k;
                if (g < 4) begin
                    ea[4*k+:4] = 4'(g);
                    eb[4*k+:4] = 4'(4 + g);
                    ec[4*k+:4] = 4'(8 + g);
                    ed[4*k+:4] = 4'(12 + g);
                end else begin
                    i = g - 4;
                    ea[4*k+:4] = 4'(i);
                    eb[4*k+:4] = 4'(4 + (i + 1) % 4);
                    ec[4*k+:4] = 4'(8 + (i + 2) % 4);
                    ed[4*k+:4] = 4'(12 + (i + 3) % 4);
                end
                em0[4*k+:4] = sig[row][2*g];
                em1[4*k+:4] = sig[row][2*g+1];
            end
        end else if (m_st[d] == M_DONE) begin
            dn = 1'b1;
        end
        return {21'd0, v, b, dn, l, er, es, ea, eb, ec, ed, em0, em1};
    endfunction

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic chk24(input string tag, input logic [23:0] o, input logic [23:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Hand-derived bundles at known positions.
    task automatic spot();
        if (m_st[0] == M_RUN && m_idx[0] == 0)
            chk24("l1_first", {o1_a, o1_b, o1_c, o1_d, o1_m0, o1_m1}, 24'h048C01);
        if (m_st[0] == M_RUN && m_idx[0] == 12)
            chk24("l1_r1s4", {o1_a, o1_b, o1_c, o1_d, o1_m0, o1_m1}, 24'h05AF1C);
        if (m_st[0] == M_RUN && m_idx[0] == 80)
            chk24("l1_r10_wrap", {o1_a, o1_b, o1_c, o1_d, o1_m0, o1_m1}, 24'h048C01);
        if (m_st[1] == M_RUN && m_idx[1] == 1) begin
            chk24("l4_s1_lane0", {o4_a[3:0], o4_b[3:0], o4_c[3:0], o4_d[3:0], o4_m0[3:0], o4_m1[3:0]}, 24'h05AF89);
            chk24("l4_s1_lane3", {o4_a[15:12], o4_b[15:12], o4_c[15:12], o4_d[15:12], o4_m0[15:12], o4_m1[15:12]}, 24'h349EEF);
        end
    endtask

    // Advance models by the inputs present at the coming edge, then compare.
    task automatic tick(input string tag);
        for (int d = 0; d < 2; d++) begin
            if (obs[d][106] && t_ready[d] && !t_abort[d]) xfers[d]++;
            if (t_abort[d]) begin
                m_st[d] = M_IDLE;
                m_idx[d] = 0;
            end else if (m_st[d] == M_RUN) begin
                if (t_ready[d]) begin
                    if (m_idx[d] == total(d) - 1) m_st[d] = M_DONE;
                    else m_idx[d]++;
                end
            end else if (t_start[d]) begin
                m_st[d] = M_RUN;
                m_idx[d] = 0;
            end else begin
                m_st[d] = M_IDLE;
                m_idx[d] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d", tag, d), obs[d], exp_vec(d));
            if (obs[d][104]) dones[d]++;
        end
        spot();
    endtask

    task automatic run(input int d, input int stop_idx, input bit rnd_rdy);
        int budget;
        budget = 400;
        while (m_st[d] == M_RUN && m_idx[d] < stop_idx && budget > 0) begin
            t_ready[d] = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick("run");
            budget--;
        end
        chk_int("run_budget", (budget > 0) ? 1 : 0, 1);
    endtask

    initial begin
        logic [127:0] held;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            t_start[d] = 1'b0; t_abort[d] = 1'b0; t_ready[d] = 1'b0;
            m_st[d] = M_IDLE; m_idx[d] = 0; xfers[d] = 0; dones[d] = 0;
        end
        #12;
        chk("reset_d0", obs[0], 128'd0);
        chk("reset_d1", obs[1], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick("idle");

        // Full LANES=1 compression at ready=1, with a start pulse during RUN.
        xfers[0] = 0; dones[0] = 0;
        t_start[0] = 1'b1; tick("start1"); t_start[0] = 1'b0;
        run(0, 30, 1'b0);
        t_start[0] = 1'b1; tick("start_in_run"); t_start[0] = 1'b0;
        run(0, 1000, 1'b0);
        tick("done_to_idle");
        chk_int("l1_xfers", xfers[0], 96);
        chk_int("l1_done_once", dones[0], 1);

        // Full LANES=4 compression with random backpressure.
        xfers[1] = 0; dones[1] = 0;
        t_start[1] = 1'b1; tick("start4"); t_start[1] = 1'b0;
        run(1, 1000, 1'b1);
        tick("done4");
        chk_int("l4_xfers", xfers[1], 20);
        chk_int("l4_done_once", dones[1], 1);

        // Stall mid round 3, then back-to-back compression from DONE.
        xfers[0] = 0; dones[0] = 0;
        t_start[0] = 1'b1; tick("start_bp"); t_start[0] = 1'b0;
        run(0, 3 * 8 + 3, 1'b0);
        held = obs[0];
        t_ready[0] = 1'b0;
        repeat (5) begin
            tick("bp");
            chk("bp_hold", obs[0], held);
        end
        run(0, 1000, 1'b0);
        t_start[0] = 1'b1; tick("b2b_start"); t_start[0] = 1'b0;
        run(0, 1000, 1'b1);
        tick("done_to_idle2");
        chk_int("b2b_xfers", xfers[0], 192);
        chk_int("b2b_dones", dones[0], 2);

        // Abort in round 5 together with start and handshake.
        dones[0] = 0;
        t_start[0] = 1'b1; tick("start_ab"); t_start[0] = 1'b0;
        run(0, 5 * 8 + 3, 1'b1);
        t_abort[0] = 1'b1; t_start[0] = 1'b1; t_ready[0] = 1'b1;
        tick("abort");
        t_abort[0] = 1'b0; t_start[0] = 1'b0;
        chk("abort_idle", obs[0], 128'd0);
        tick("post_abort");
        chk_int("abort_no_done", dones[0], 0);
        t_start[0] = 1'b1; tick("restart"); t_start[0] = 1'b0;
        chk_int("restart_rnd_step", {o1_rnd, o1_step}, 0);

        // Asynchronous reset while both instances run.
        t_start[1] = 1'b1; tick("start4b"); t_start[1] = 1'b0;
        t_ready[0] = 1'b1; t_ready[1] = 1'b1;
        tick("pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_st[d] = M_IDLE; m_idx[d] = 0;
            t_ready[d] = 1'b0;
        end
        chk("async_rst_d0", obs[0], 128'd0);
        chk("async_rst_d1", obs[1], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
